// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq command sequencer.
// Opcode encoding matches the alu block's op input.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StResp  = 2'b10
  } seq_state_e;

  // Bit positions inside the {N,V,Z} flag vectors.
  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_N = 2;

  function automatic logic [2:0] pack_flags(input logic n, input logic v, input logic z);
    logic [2:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_V] = v;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Single-outstanding command sequencer driving a combinational alu: registers the command,
// samples the alu result/flags one cycle later and returns them over a valid/ready channel.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_cmp,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  // alu interface
  output logic [WIDTH-1:0] alu_ain,
  output logic [WIDTH-1:0] alu_bin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic [2:0]       status
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] ain_q, bin_q;
  alu_op_e          op_q;
  logic             cmp_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       flags_q;
  logic [2:0]       status_q;

  logic             accept;
  logic             capture;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands only move on acceptance so the alu inputs never glitch between commands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ain_q <= '0;
      bin_q <= '0;
      op_q  <= ALU_ADD;
      cmp_q <= 1'b0;
    end else if (accept) begin
      ain_q <= req_a;
      bin_q <= req_b;
      op_q  <= alu_op_e'(req_op);
      cmp_q <= req_cmp;
    end
  end

  // Compare-only commands update flags/status but keep the previous result visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
      status_q <= '0;
    end else if (capture) begin
      flags_q  <= pack_flags(alu_n, alu_v, alu_z);
      status_q <= pack_flags(alu_n, alu_v, alu_z);
      if (!cmp_q) begin
        result_q <= alu_out;
      end
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  assign alu_ain   = ain_q;
  assign alu_bin   = bin_q;
  assign alu_op    = op_q;
  assign rsp_data  = result_q;
  assign rsp_flags = flags_q;
  assign status    = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural alu model and an expected-response queue.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic         req_cmp;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] alu_ain;
  logic [W-1:0] alu_bin;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_z;
  logic         alu_v;
  logic         alu_n;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_flags;
  logic [2:0]   status;

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   flags;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_cmp   (req_cmp),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_ain   (alu_ain),
    .alu_bin   (alu_bin),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .alu_v     (alu_v),
    .alu_n     (alu_n),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .status    (status)
  );

  // Behavioural stand-in for the alu block.
  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = alu_ain + alu_bin;
        alu_v   = (alu_ain[W-1] == alu_bin[W-1]) && (alu_out[W-1] != alu_ain[W-1]);
      end
      2'b01: begin
        alu_out = alu_ain - alu_bin;
        alu_v   = (alu_ain[W-1] != alu_bin[W-1]) && (alu_out[W-1] != alu_ain[W-1]);
      end
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_z = (alu_out == '0);
    alu_n = alu_out[W-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    check({tag, "_qnonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rsp_data, e.data);
      check({tag, "_flags"}, rsp_flags, e.flags);
      check({tag, "_status"}, status, e.flags);
    end
  endtask

  // Full command at minimum turnaround; expected response queued at drive time.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic cmp,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic [2:0] ef);
    exp_q.push_back('{data: ed, flags: ef});
    @(negedge clk);
    check({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_cmp   = cmp;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_ain"}, alu_ain, a);
    check({tag, "_bin"}, alu_bin, b);
    check({tag, "_op"}, alu_op, op);
    check({tag, "_issue_rsp_valid"}, rsp_valid, 0);
    check({tag, "_issue_req_ready"}, req_ready, 0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check_rsp(tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_done_rsp_valid"}, rsp_valid, 0);
    check({tag, "_done_req_ready"}, req_ready, 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_cmp   = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outputs", {rsp_data, rsp_flags, status, alu_ain, alu_bin, alu_op}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    run_cmd("add_ovf", 2'b00, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 3'b110);
    run_cmd("sub_zero", 2'b01, 1'b0, 16'h000F, 16'h000F, 16'h0000, 3'b001);
    run_cmd("sub_ovf", 2'b01, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
    run_cmd("and", 2'b10, 1'b0, 16'h1000, 16'h1001, 16'h1000, 3'b000);
    run_cmd("notb", 2'b11, 1'b0, 16'hABCD, 16'h0001, 16'hFFFE, 3'b100);
    run_cmd("set_1234", 2'b00, 1'b0, 16'h1000, 16'h0234, 16'h1234, 3'b000);
    run_cmd("cmp_sub", 2'b01, 1'b1, 16'h0005, 16'h0005, 16'h1234, 3'b001);

    // Backpressure: response held 4 cycles while the next request waits at the input.
    exp_q.push_back('{data: 16'h0002, flags: 3'b000});
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_cmp   = 1'b0;
    req_a     = 16'h0001;
    req_b     = 16'h0001;
    @(negedge clk);
    req_a = 16'h0003;
    req_b = 16'h0004;
    exp_q.push_back('{data: 16'h0007, flags: 3'b000});
    @(negedge clk);
    check_rsp("bp_first");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_data_stable", {rsp_data, rsp_flags}, {16'h0002, 3'b000});
      check("bp_ain_hold", alu_ain, 16'h0001);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_idle_req_ready", req_ready, 1);
    check("bp_idle_ain", alu_ain, 16'h0001);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_ain", alu_ain, 16'h0003);
    check("bp_second_bin", alu_bin, 16'h0004);
    @(negedge clk);
    check("bp_second_valid", rsp_valid, 1);
    check_rsp("bp_second");
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during ISSUE discards the command.
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_cmp   = 1'b0;
    req_a     = 16'h0009;
    req_b     = 16'h0002;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_issue", req_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_async_req_ready", req_ready, 1);
    check("abort_async_outputs",
          {rsp_valid, rsp_data, rsp_flags, status, alu_ain, alu_bin, alu_op}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_release_req_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
      check("abort_outputs_zero", {rsp_data, rsp_flags, status, alu_ain, alu_bin}, 0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle command sequencer that acts as the initiator for the combinational `alu` block. It accepts one ALU command at a time over a valid/ready request channel and drives registered operands and opcode onto the `alu` ports. It then samples the ALU result and Z/V/N flags, maintains a status register, and returns the result over a valid/ready response channel. It sits between the datapath controller and the `alu` instance.

## Interface
- `WIDTH`, default 16: operand and result width.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  sequencer can accept a command.
- `req_op`  in  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 NOTB (~B).
- `req_cmp`  in  1  compare-only: update status, leave result register unchanged.
- `req_a`, `req_b`  in  WIDTH  operands A and B.
- `alu_ain`, `alu_bin`  out  WIDTH  registered operands to `alu`.
- `alu_op`  out  2  registered opcode to `alu`.
- `alu_out`  in  WIDTH  ALU result.
- `alu_z`, `alu_v`, `alu_n`  in  1  ALU zero, signed-overflow and negative flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  WIDTH  result register.
- `rsp_flags`  out  3  flags of this command, {N,V,Z}.
- `status`  out  3  sticky status register {N,V,Z}; holds the flags of the last completed command.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ISSUE: ALU inputs stable for one cycle.
  - RESP: `rsp_valid`=1.
- Transitions:
  - IDLE -> ISSUE on `req_valid`&`req_ready`. Load `alu_ain`, `alu_bin`, `alu_op` from the request and latch `req_cmp`.
  - ISSUE -> RESP unconditionally. At this edge:
    - capture `alu_z`/`alu_v`/`alu_n` into `rsp_flags` and `status`;
    - capture `alu_out` into the result register only if the latched cmp bit is 0.
  - RESP -> IDLE on `rsp_ready`=1.
- `req_ready` = (state==IDLE); `rsp_valid` = (state==RESP). Both are combinational from the state register only.
- With cmp=1, `rsp_data` presents the unchanged previous result register.
- Flags are taken verbatim from `alu`; the sequencer computes no arithmetic. For AND/NOTB, V from `alu` is 0.
- `alu_*` outputs hold their last values outside ISSUE. There are no spurious changes.
- `status` changes only at the ISSUE->RESP edge.

## Timing
- Request accepted at edge E0. ALU inputs valid during cycle 1. Result and flags captured at E1. `rsp_valid` is high from cycle 2.
- Minimum turnaround is 3 cycles per command (response accepted at E2, IDLE in cycle 3). No request overlap: `req_ready`=0 in ISSUE and RESP.
- Response backpressure: while `rsp_ready`=0, `rsp_data` and `rsp_flags` remain stable and `rsp_valid` stays 1 indefinitely.
- `req_valid` asserted outside IDLE is ignored and not queued. The request is held by the producer until ready.
- Reset values:
  - state IDLE, so `req_ready`=1 once `reset_n` deasserts;
  - `rsp_valid`=0;
  - `rsp_data`, `rsp_flags`, `status`, `alu_ain`, `alu_bin` = 0;
  - `alu_op`=00.
- Reset asserted mid-command (ISSUE or RESP) aborts it immediately and asynchronously. No response is produced, and the in-flight result and flags are discarded.

## Structure
- Package `alu_seq_pkg`:
  - opcode enum: `ALU_ADD`=2'b00, `ALU_SUB`=2'b01, `ALU_AND`=2'b10, `ALU_NOTB`=2'b11;
  - state enum: IDLE, ISSUE, RESP;
  - flag index constants: `FLG_Z`=0, `FLG_V`=1, `FLG_N`=2.
- No sub-module inside `alu_seq`; the existing `alu` is instantiated alongside it by the parent and by the bench.
- Roughly 150-200 lines: FSM, operand/opcode registers, result/flag/status registers.

## Test plan
- ADD 0x7FFF + 0x0001, cmp=0 -> `rsp_data`=0x8000, `rsp_flags`={N=1,V=1,Z=0}, `rsp_valid` first high 2 cycles after acceptance.
- SUB 0x000F - 0x000F, then SUB 0x8000 - 0x0001 -> 0x0000 with {0,0,1}, then 0x7FFF with {0,1,0}; `status` tracks each.
- AND 0x1000 & 0x1001 -> 0x1000 {0,0,0}; NOTB with B=0x0001 -> 0xFFFE {1,0,0}.
- Result register 0x1234, then cmp=1 SUB 0x0005 - 0x0005 -> `rsp_data`=0x1234, `rsp_flags`/`status`={0,0,1}.
- `rsp_ready` held low 4 cycles with `req_valid` high and a new operand -> response stable, `req_ready`=0, second command accepted only after the response handshake.
- `reset_n` pulsed low during ISSUE -> `rsp_valid` never rises; all outputs 0; `req_ready`=1 in the first cycle after release.
